// File: rtl/fio_pkg.sv
// Shared constants and types for the FileIO memory readback engine.
package fio_pkg;

  localparam int mem_size       = 256;
  localparam int shmem_size     = 256;
  localparam int mem_addr_width = $clog2(mem_size);
  localparam int addr_width     = $clog2(mem_size + shmem_size);

  localparam int LINE_W         = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int WIDX_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_SEND    = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  // Line addresses wrap around the whole global+shared space.
  function automatic logic [addr_width-1:0] next_line(input logic [addr_width-1:0] a);
    return a + 1'b1;
  endfunction

endpackage

// File: rtl/fio_line_serializer.sv
// Turns one captured memory line into WORDS_PER_LINE stream words,
// lowest word first, holding each word stable under back-pressure.
module fio_line_serializer
  import fio_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [LINE_W-1:0]     line_in,
  input  logic [addr_width-1:0] line_addr,
  input  logic                  last_line,
  input  logic                  ready,
  output logic                  valid,
  output logic [WORD_W-1:0]     data,
  output logic [addr_width-1:0] line,
  output logic                  last,
  output logic                  word_done
);

  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_LINE - 1);

  logic [LINE_W-1:0]     shift_reg;
  logic [WIDX_W-1:0]     widx_reg;
  logic                  valid_reg;
  logic                  last_line_reg;
  logic [addr_width-1:0] line_reg;
  logic                  xfer;

  assign xfer      = valid_reg & ready;
  assign word_done = xfer && (widx_reg == LAST_WORD);

  // Load a fresh line, then shift one word out per accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg     <= '0;
      widx_reg      <= '0;
      valid_reg     <= 1'b0;
      last_line_reg <= 1'b0;
      line_reg      <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
      widx_reg  <= '0;
    end else if (load) begin
      shift_reg     <= line_in;
      widx_reg      <= '0;
      valid_reg     <= 1'b1;
      line_reg      <= line_addr;
      last_line_reg <= last_line;
    end else if (xfer) begin
      shift_reg <= {{WORD_W{1'b0}}, shift_reg[LINE_W-1:WORD_W]};
      widx_reg  <= widx_reg + 1'b1;
      if (widx_reg == LAST_WORD) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = shift_reg[WORD_W-1:0];
  assign line  = line_reg;
  assign last  = valid_reg && last_line_reg && (widx_reg == LAST_WORD);

endmodule

// File: rtl/fio_mem_dump.sv
// Readback engine: sweeps a range of memory lines through the FileIO read
// port, waits out the read latency per line and streams each line as words.
module fio_mem_dump
  import fio_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   line_count,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] FIO_ADDR,
  output logic                  FIO_MEMWRITE,
  input  logic [LINE_W-1:0]     FIO_READ_DATA,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [WORD_W-1:0]     dout_data,
  output logic [addr_width-1:0] dout_line,
  output logic                  dout_last
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0]    LAT_LOAD = LAT_W'(READ_LAT - 1);
  localparam logic [addr_width:0] ONE_LINE = (addr_width + 1)'(1);

  state_t                state, state_next;
  logic [addr_width-1:0] cur_addr;
  logic [addr_width:0]   lines_rem;
  logic [LAT_W-1:0]      lat_cnt;
  logic [addr_width-1:0] fio_addr_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic                  ser_load;
  logic                  word_done;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    ser_load   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (line_count == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT: begin
        if (lat_cnt == '0) begin
          state_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        ser_load   = 1'b1;
        state_next = S_SEND;
      end
      S_SEND: begin
        if (word_done) begin
          state_next = (lines_rem == ONE_LINE) ? S_FIN : S_ISSUE;
        end
      end
      S_FIN:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
      ser_load   = 1'b0;
    end
  end

  // Sweep bookkeeping: address/line counters, read latency and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr     <= '0;
      lines_rem    <= '0;
      lat_cnt      <= '0;
      fio_addr_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      busy_reg <= state_next inside {S_ISSUE, S_WAIT, S_CAPTURE, S_SEND};
      done_reg <= (state == S_FIN) && !abort;
      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (start && (line_count != '0)) begin
              cur_addr  <= base_addr;
              lines_rem <= line_count;
            end
          end
          S_ISSUE: begin
            fio_addr_reg <= cur_addr;
            lat_cnt      <= LAT_LOAD;
          end
          S_WAIT: begin
            if (lat_cnt != '0) begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          S_SEND: begin
            if (word_done) begin
              lines_rem <= lines_rem - 1'b1;
              cur_addr  <= next_line(cur_addr);
            end
          end
          default: ;
        endcase
      end
    end
  end

  fio_line_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort),
    .load      (ser_load),
    .line_in   (FIO_READ_DATA),
    .line_addr (cur_addr),
    .last_line (lines_rem == ONE_LINE),
    .ready     (dout_ready),
    .valid     (dout_valid),
    .data      (dout_data),
    .line      (dout_line),
    .last      (dout_last),
    .word_done (word_done)
  );

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign FIO_ADDR     = fio_addr_reg;
  assign FIO_MEMWRITE = 1'b0;

endmodule

// File: tb/tb_fio_mem_dump.sv
// Randomised bench for fio_mem_dump with a queue-based word model.
module tb_fio_mem_dump;

  localparam int AW = 9;
  localparam int NLINES = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   line_count = '0;
  logic          busy, done;
  logic [AW-1:0] FIO_ADDR;
  logic          FIO_MEMWRITE;
  logic [255:0]  FIO_READ_DATA;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic [31:0]   dout_data;
  logic [AW-1:0] dout_line;
  logic          dout_last;

  fio_mem_dump #(.READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .line_count(line_count),
    .busy(busy), .done(done),
    .FIO_ADDR(FIO_ADDR), .FIO_MEMWRITE(FIO_MEMWRITE), .FIO_READ_DATA(FIO_READ_DATA),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_line(dout_line), .dout_last(dout_last)
  );

  always #5 clk = ~clk;

  // Memory with a two-cycle read latency from address change to data.
  logic [255:0] mem [NLINES];
  logic [255:0] rd_pipe0 = '0, rd_pipe1 = '0;
  always @(posedge clk) begin
    rd_pipe0 <= mem[FIO_ADDR];
    rd_pipe1 <= rd_pipe0;
  end
  assign FIO_READ_DATA = rd_pipe1;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] line;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  // Observation state shared with the main sequence.
  int            done_seen = 0;
  int            last_done_cyc = 0;
  int            xfer_cnt = 0;
  logic          fv_arm = 1'b0;
  int            first_valid_cyc = -1;
  logic [31:0]   first_word = '0;
  logic [31:0]   last_word = '0;
  logic          rec_addr = 1'b0;
  logic [AW-1:0] rec_prev = '0;
  logic [AW-1:0] addr_log[$];
  logic          rdy_random = 1'b0;

  // Ready driver: held high, or a fresh coin flip every cycle.
  always @(posedge clk) begin
    #1;
    dout_ready = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Compare process: checks stream, hold behaviour and status every cycle.
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_last = 1'b0;
  logic [31:0]   prev_data = '0;
  logic [AW-1:0] prev_line = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      chk("memwrite_zero", FIO_MEMWRITE, 0);
      if (prev_valid && !prev_ready && !prev_abort) begin
        chk("hold_valid", dout_valid, 1);
        chk("hold_data", dout_data, prev_data);
        chk("hold_line", dout_line, prev_line);
        chk("hold_last", dout_last, prev_last);
      end
      if (dout_valid) chk("busy_while_valid", busy, 1);
      if (fv_arm && dout_valid) begin
        fv_arm = 1'b0;
        first_valid_cyc = cyc;
        first_word = dout_data;
      end
      if (dout_valid && dout_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          e = exp_q.pop_front();
          chk("word_data", dout_data, e.data);
          chk("word_line", dout_line, e.line);
          chk("word_last", dout_last, e.last);
          if (dout_last) last_word = dout_data;
        end
      end
      if (done) begin
        done_seen++;
        last_done_cyc = cyc;
        chk("done_after_all_words", exp_q.size(), 0);
      end
      if (rec_addr && busy && FIO_ADDR != rec_prev) begin
        addr_log.push_back(FIO_ADDR);
        rec_prev = FIO_ADDR;
      end
      prev_valid = dout_valid;
      prev_ready = dout_ready;
      prev_abort = abort;
      prev_data  = dout_data;
      prev_line  = dout_line;
      prev_last  = dout_last;
    end
  end

  int start_cyc = 0;

  // Issues a start pulse and appends the words the sweep must produce.
  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n);
    exp_t e;
    logic [AW-1:0] a;
    for (int l = 0; l < int'(n); l++) begin
      a = AW'(int'(b) + l);
      for (int j = 0; j < 8; j++) begin
        e.data = mem[a][j*32 +: 32];
        e.line = a;
        e.last = (l == int'(n) - 1) && (j == 7);
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    base_addr = b;
    line_count = n;
    start = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Full sweep: start, optional ignored second start, wait for done.
  task automatic run_sweep(input logic [AW-1:0] b, input logic [AW:0] n, input bit extra,
                           output int s_cyc, output int d_cyc);
    int d0;
    int bound;
    d0 = done_seen;
    d_cyc = -1;
    bound = int'(n) * 40 + 100;
    pulse_start(b, n);
    s_cyc = start_cyc;
    if (extra) begin
      repeat (6) @(posedge clk);
      #1;
      base_addr = b + 9'd100;
      line_count = 10'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < bound && done_seen == d0; i++) @(negedge clk);
    if (done_seen == d0) fail_now("done_timeout");
    else d_cyc = last_done_cyc;
    repeat (3) @(negedge clk);
    chk("done_once", done_seen - d0, 1);
    chk("words_left", exp_q.size(), 0);
  endtask

  initial begin
    int s, d, d0, x0;
    logic [AW-1:0] fa;
    logic [AW-1:0] rb;
    logic [AW:0]   rn;

    for (int k = 0; k < NLINES; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (k < 256) mem[k][j*32 +: 32] = {8'(k), 8'(j), 16'hA5A5};
        else mem[k][j*32 +: 32] = $urandom;
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_addr", FIO_ADDR, 0);
    chk("rst_data", dout_data, 0);
    chk("rst_line", dout_line, 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: four lines, ready high, exact timing
    fv_arm = 1'b1;
    run_sweep(9'd0, 10'd4, 1'b0, s, d);
    chk("t1_first_valid_lat", first_valid_cyc - s, 4);
    chk("t1_first_word", first_word, 32'h0000A5A5);
    chk("t1_last_word", last_word, 32'h0307A5A5);
    chk("t1_done_lat", d - s, 49);

    // 2: same sweep under random back-pressure
    rdy_random = 1'b1;
    run_sweep(9'd0, 10'd4, 1'b0, s, d);
    rdy_random = 1'b0;

    // 3: address wrap 510, 511, 0
    addr_log.delete();
    rec_prev = FIO_ADDR;
    rec_addr = 1'b1;
    run_sweep(9'd510, 10'd3, 1'b0, s, d);
    rec_addr = 1'b0;
    chk("t3_addr_count", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      chk("t3_addr0", addr_log[0], 510);
      chk("t3_addr1", addr_log[1], 511);
      chk("t3_addr2", addr_log[2], 0);
    end

    // 4: zero-length sweep
    fa = FIO_ADDR;
    x0 = xfer_cnt;
    pulse_start(9'd7, 10'd0);
    @(negedge clk);
    chk("t4_done_early", done, 0);
    @(negedge clk);
    chk("t4_done", done, 1);
    @(negedge clk);
    chk("t4_done_pulse", done, 0);
    chk("t4_addr_same", FIO_ADDR, fa);
    chk("t4_no_words", xfer_cnt - x0, 0);

    // 5: abort on the fifth word of line 1, then a fresh sweep
    d0 = done_seen;
    x0 = xfer_cnt;
    pulse_start(9'd0, 10'd4);
    for (int i = 0; i < 200 && (xfer_cnt - x0) < 12; i++) begin
      @(posedge clk); #1;
    end
    chk("t5_word13", dout_data, 32'h0104A5A5);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_valid_off", dout_valid, 0);
    chk("t5_busy_off", busy, 0);
    chk("t5_done_off", done, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_done", done_seen - d0, 0);
    run_sweep(9'd2, 10'd1, 1'b0, s, d);

    // 6: asynchronous reset in WAIT
    pulse_start(9'd5, 10'd2);
    @(posedge clk); #1;
    chk("t6_busy", busy, 1);
    chk("t6_addr", FIO_ADDR, 5);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", FIO_ADDR, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_line", dout_line, 0);
    chk("t6_rst_data", dout_data, 0);
    chk("t6_rst_last", dout_last, 0);
    chk("t6_rst_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // 6b: second start while busy is ignored
    x0 = xfer_cnt;
    run_sweep(9'd40, 10'd2, 1'b1, s, d);
    chk("t6_word_count", xfer_cnt - x0, 16);

    // Randomised sweeps
    for (int it = 0; it < 6; it++) begin
      rb = AW'($urandom_range(0, NLINES - 1));
      rn = (AW + 1)'($urandom_range(1, 5));
      rdy_random = ($urandom_range(0, 1) == 1);
      run_sweep(rb, rn, (it == 3), s, d);
      $display("sweep %0d base=%0d lines=%0d done after %0d cycles", it, rb, rn, d - s);
    end
    rdy_random = 1'b0;

    // Whole address space exactly once
    x0 = xfer_cnt;
    run_sweep(9'd100, 10'd512, 1'b0, s, d);
    chk("full_words", xfer_cnt - x0, 4096);
    chk("full_done_lat", d - s, 512 * 12 + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
